// File: rtl/control_sequencer_if.sv
// Memory handshake and sequencer outputs for the control_sequencer.
// SEQ_ONEHOT_CHECK_EN adds the onehot_err signal.
interface control_sequencer_if #(
  parameter int unsigned IR_W = 16
) ();
  logic [IR_W-1:0] mem_rdata;
  logic            mem_ready;
  logic [13:0]     state;
  logic [IR_W-1:0] ir;
  logic            fetch_req;
  logic            illegal_op;
`ifdef SEQ_ONEHOT_CHECK_EN
  logic            onehot_err;

  modport master (
    output mem_rdata, mem_ready,
    input  state, ir, fetch_req, illegal_op, onehot_err
  );
  modport slave (
    input  mem_rdata, mem_ready,
    output state, ir, fetch_req, illegal_op, onehot_err
  );
`else
  modport master (
    output mem_rdata, mem_ready,
    input  state, ir, fetch_req, illegal_op
  );
  modport slave (
    input  mem_rdata, mem_ready,
    output state, ir, fetch_req, illegal_op
  );
`endif
endinterface

// File: rtl/control_sequencer.sv
// One-hot fetch/decode/execute sequencer owning the IR and shift counter.
// Optional SEQ_ONEHOT_CHECK_EN forces recovery to S0 on a corrupted state register.
module control_sequencer #(
  parameter int unsigned IR_W  = 16,
  parameter int unsigned CNT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  control_sequencer_if.slave bus
);

  typedef enum logic [13:0] {
    StFetch   = 14'h0001,
    StDecode  = 14'h0002,
    StAlu0    = 14'h0004,
    StAlu1    = 14'h0008,
    StMem0    = 14'h0010,
    StMemWait = 14'h0020,
    StBr0     = 14'h0040,
    StBr1     = 14'h0080,
    StCall0   = 14'h0100,
    StCall1   = 14'h0200,
    StShift   = 14'h0400,
    StStack0  = 14'h0800,
    StStack1  = 14'h1000,
    StTrap    = 14'h2000
  } state_e;

  state_e          state_q;
  logic [IR_W-1:0] ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic            onehot_bad;
  logic [13:0]     state_bits;

  assign state_bits = state_q;

`ifdef SEQ_ONEHOT_CHECK_EN
  assign onehot_bad     = !$onehot(state_bits);
  assign bus.onehot_err = onehot_bad;
`else
  assign onehot_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else if (onehot_bad) begin
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (bus.mem_ready) begin
            ir_q    <= bus.mem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (!ir_q[IR_W-1]) begin
            state_q <= StAlu0;
          end else begin
            case (ir_q[IR_W-2 -: 3])
              3'b000:  state_q <= StMem0;
              3'b001:  state_q <= StBr0;
              3'b010:  state_q <= StCall0;
              3'b011: begin
                state_q <= StShift;
                cnt_q   <= ir_q[CNT_W-1:0];
              end
              3'b100:  state_q <= StStack0;
              default: state_q <= StTrap;
            endcase
          end
        end
        StAlu0:    state_q <= StAlu1;
        StAlu1:    state_q <= StFetch;
        StMem0:    state_q <= StMemWait;
        StMemWait: if (bus.mem_ready) state_q <= StFetch;
        StBr0:     state_q <= StBr1;
        StBr1:     state_q <= StFetch;
        StCall0:   state_q <= StCall1;
        StCall1:   state_q <= StFetch;
        StShift: begin
          // n=0 and n=1 both leave after a single cycle
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= StFetch;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StStack0:  state_q <= StStack1;
        StStack1:  state_q <= StFetch;
        StTrap:    state_q <= StFetch;
        default:   state_q <= StFetch;
      endcase
    end
  end

  assign bus.state      = state_bits;
  assign bus.ir         = ir_q;
  assign bus.fetch_req  = state_bits[0];
  assign bus.illegal_op = state_bits[13];

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench for control_sequencer: a per-cycle expected
// state/ir trace is built from the instruction rules and checked by a monitor.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  control_sequencer_if #(.IR_W(16)) bus ();

  control_sequencer #(.IR_W(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [15:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  logic [15:0] cur_ir = 16'h0000;

  // Monitor: one expected entry per clock cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL underflow cyc%0d: got state %h, no expectation queued", cyc, bus.state);
      end else begin
        exp_t        e;
        logic [13:0] es;
        e  = exp_q.pop_front();
        es = 14'(1) << e.st;
        if (bus.state !== es || bus.ir !== e.ir || bus.illegal_op !== (e.st == 13) ||
            bus.fetch_req !== (e.st == 0)) begin
          n_err++;
          $display("FAIL trace cyc%0d: state %h ir %h ill %b fr %b, expected state %h ir %h ill %b fr %b",
                   cyc, bus.state, bus.ir, bus.illegal_op, bus.fetch_req,
                   es, e.ir, (e.st == 13), (e.st == 0));
        end
`ifdef SEQ_ONEHOT_CHECK_EN
        if (bus.onehot_err !== 1'b0) begin
          n_err++;
          $display("FAIL onehot_err cyc%0d: got %b expected 0", cyc, bus.onehot_err);
        end
`endif
      end
    end
  end

  // One cycle: drive inputs for it, queue what the DUT must show, advance.
  task automatic step(input logic rdy, input logic [15:0] rdata, input int st);
    exp_t e;
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;
    e.st = st;
    e.ir = cur_ir;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Reference: fetch waits w cycles, memory access waits m cycles.
  task automatic run_instr(input logic [15:0] instr, input int w, input int m);
    int seq[$];
    int n;
    for (int i = 0; i < w; i++) step(1'b0, 16'($urandom), 0);
    step(1'b1, instr, 0);
    cur_ir = instr;
    step(1'($urandom), 16'($urandom), 1);
    if (!instr[15]) seq = '{2, 3};
    else begin
      case (instr[14:12])
        3'd0: seq = '{4};
        3'd1: seq = '{6, 7};
        3'd2: seq = '{8, 9};
        3'd3: begin
          n = (instr[3:0] == 0) ? 1 : int'(instr[3:0]);
          for (int i = 0; i < n; i++) seq.push_back(10);
        end
        3'd4: seq = '{11, 12};
        default: seq = '{13};
      endcase
    end
    foreach (seq[i]) step(1'($urandom), 16'($urandom), seq[i]);
    if (instr[15] && instr[14:12] == 3'd0) begin
      for (int i = 0; i < m; i++) step(1'b0, 16'($urandom), 5);
      step(1'b1, 16'($urandom), 5);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    int found;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'h0001);
    check("rst_ir", 32'(bus.ir), 32'h0);
    check("rst_ill", 32'(bus.illegal_op), 32'h0);
    check("rst_fetch", 32'(bus.fetch_req), 32'h1);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_instr(16'h2345, 3, 0);
    run_instr(16'h8800, 0, 2);
    run_instr(16'hB003, 0, 0);
    run_instr(16'hB000, 0, 0);
    run_instr(16'hD000, 0, 0);
    run_instr(16'hBFFF, 1, 0);
    for (int k = 0; k < 80; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (k % 4 == 0) r[15:12] = 4'hB;
      if (k % 4 == 1) r[15:12] = 4'h8;
      run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    mon_en = 1'b0;
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset in the middle of a memory wait.
    bus.mem_rdata = 16'h8800;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.state === 14'h0020) found = 1;
    end
    check("reach_s5", 32'(found), 32'h1);
    check("s5_ir", 32'(bus.ir), 32'h8800);
    @(posedge clk);
    #2;
    check("s5_hold", 32'(bus.state), 32'h0020);
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(bus.state), 32'h0001);
    check("async_ir", 32'(bus.ir), 32'h0);
    check("async_ill", 32'(bus.illegal_op), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
